arcade_input_mapper: RTL and testbench
======================================

Name: arcade_input_mapper

Overview:
- Parametrised player-input front end for arcade emu tops.
- Decodes hps_io PS/2 key events into per-player key state and merges it with per-player joystick words.
- Applies rotation remap (0/90/180/270) and SOCD cleaning; generates timed coin pulses.
- Sits between hps_io and the game core; the core's in0/in1 inversion and packing stay in the top.

Parameters:
- PLAYERS, 2, number of players (1..4); only players 0 and 1 have keyboard maps.
- NBTN, 4, action buttons per player (1..10).
- COIN_PULSE, 16, coin high time and minimum gap time, in clk_sys cycles (>=1).

Ports:
- clk_sys  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- ps2_key  in  11  [10] toggle, [9] pressed, [8] extended, [7:0] scancode
- joystick  in  PLAYERS*16  player p at [16p+15:16p]; bit0 R, 1 L, 2 D, 3 U, 4..3+NBTN buttons, 4+NBTN start, 5+NBTN coin
- joy_merge  in  1  1: OR all joystick words into every player
- rot  in  2  0 none, 1 90°CW, 2 180°, 3 270°CW
- dir_out  out  PLAYERS*4  per player {U,D,L,R} after remap/SOCD
- btn_out  out  PLAYERS*NBTN  action buttons
- start_out  out  PLAYERS  start buttons
- coin_out  out  PLAYERS  timed coin pulses

Behaviour:
- Clock and reset: one clock, clk_sys. Reset is asynchronous and active-low on RESET_N. All outputs, key-state registers and the toggle tracker reset to 0; coin FSMs reset to IDLE.
- Key event detection:
  - A key event is detected when ps2_key[10] differs from its registered copy.
  - On an event, the mapped key-state bit is loaded with ps2_key[9].
  - Unmapped codes are ignored.
  - Extended bit is matched exactly.
- Player 0 keymap:
  - Directions: E075 U, E072 D, E06B L, E074 R.
  - Buttons: 014 b0, 011 b1, 029 b2, 012 b3.
  - 016 start, 02E coin.
- Player 1 keymap:
  - Directions: 02D U, 02B D, 023 L, 034 R.
  - Buttons: 01C b0, 01B b1, 015 b2, 01D b3.
  - 01E start, 036 coin.
- Buttons with index >=4, and players >=2, are joystick only.
- Merge: raw = key state OR joystick[p]. When joy_merge=1, use the OR of all joystick words instead of joystick[p].
- Rotation, applied on {U,D,L,R}:
  - rot=1: U<-L, D<-R, L<-D, R<-U.
  - rot=2: U<-D, D<-U, L<-R, R<-L.
  - rot=3: U<-R, D<-L, L<-U, R<-D.
- SOCD cleaning is applied after rotation: U&D both set gives neither; L&R both set gives neither.
- Latency:
  - Joystick and rot changes reach dir/btn/start outputs on the next edge (1 cycle, registered).
  - Keyboard: the event sampled at edge n updates key state at n; outputs reflect it at n+1.
- Coin FSM, one per player; request = merged coin bit:
  - IDLE: a rising edge of request moves to PULSE and loads cnt=COIN_PULSE-1. coin_out rises on the same edge.
  - PULSE: coin_out=1; decrement cnt. At cnt=0, go to GAP with cnt=COIN_PULSE-1 and coin_out=0.
  - GAP: coin_out=0; decrement cnt. At 0, go to IDLE.
  - Request edges during PULSE or GAP are dropped, not queued.
  - A request held high through GAP does not retrigger; a fresh rising edge is required.
  - The edge detector is updated every cycle in all states.
  - Counter width is $clog2(COIN_PULSE+1).
- Reset mid-operation: outputs drop asynchronously. Held keys are forgotten until the next press event.

Optional Feature:
- Macro: ARCADE_INPUT_AUTOFIRE_EN.
- Defined:
  - Adds input autofire_mask [NBTN-1:0] and parameter AF_PERIOD (default 65536).
  - One free-running shared counter of AF_PERIOD cycles drives a phase bit that toggles at wrap.
  - A masked button held outputs (held AND phase). Phase resets to 1, so the first cycle after reset is asserted.
- Undefined: no port and no counter; buttons pass straight through.

Decomposition:
- Package arcade_input_pkg:
  - Keycode localparams (9-bit with extended bit).
  - Joystick bit indices, expressed as functions of NBTN.
  - rot_e enum: ROT_0, ROT_90, ROT_180, ROT_270.
  - coin_state_e enum: IDLE, PULSE, GAP.
- Sub-module arcade_coin_pulse (COIN_PULSE parameter, req in, pulse out), instantiated per player in a generate loop.

Test Plan:
- Press E075 (toggle flip, pressed=1), rot=0 -> dir_out[3] (P0 U)=1 one cycle after key-state update. Release -> 0.
- rot=1, joystick[0] bit1 (L) held -> P0 dir_out U=1, others 0. rot=2 -> R=1.
- Joystick U+D+L held -> U=D=0, L=1 (SOCD).
- COIN_PULSE=4: coin bit rises -> coin_out high exactly 4 cycles, low 4 cycles. A second edge inside that window gives no pulse. An edge after the window gives a new 4-cycle pulse.
- joy_merge=1, joystick[1] b0 set -> btn_out b0 set for both players. joy_merge=0 -> only P1.
- Assert RESET_N low during PULSE with keys held -> all outputs 0 immediately. After release, outputs stay 0 until new key events arrive.

Source files
------------

// File: rtl/arcade_input_pkg.sv
// Shared keycodes, joystick bit layout, rotation/coin enums and direction helpers
// for the arcade input mapper.
package arcade_input_pkg;

   // 9-bit keycodes: {extended, scancode}
   localparam logic [8:0] KEY_P0_U     = 9'h175;
   localparam logic [8:0] KEY_P0_D     = 9'h172;
   localparam logic [8:0] KEY_P0_L     = 9'h16B;
   localparam logic [8:0] KEY_P0_R     = 9'h174;
   localparam logic [8:0] KEY_P0_B0    = 9'h014;
   localparam logic [8:0] KEY_P0_B1    = 9'h011;
   localparam logic [8:0] KEY_P0_B2    = 9'h029;
   localparam logic [8:0] KEY_P0_B3    = 9'h012;
   localparam logic [8:0] KEY_P0_START = 9'h016;
   localparam logic [8:0] KEY_P0_COIN  = 9'h02E;

   localparam logic [8:0] KEY_P1_U     = 9'h02D;
   localparam logic [8:0] KEY_P1_D     = 9'h02B;
   localparam logic [8:0] KEY_P1_L     = 9'h023;
   localparam logic [8:0] KEY_P1_R     = 9'h034;
   localparam logic [8:0] KEY_P1_B0    = 9'h01C;
   localparam logic [8:0] KEY_P1_B1    = 9'h01B;
   localparam logic [8:0] KEY_P1_B2    = 9'h015;
   localparam logic [8:0] KEY_P1_B3    = 9'h01D;
   localparam logic [8:0] KEY_P1_START = 9'h01E;
   localparam logic [8:0] KEY_P1_COIN  = 9'h036;

   // Key-state slots: 0 R, 1 L, 2 D, 3 U, 4..7 b0..b3, 8 start, 9 coin
   localparam logic [3:0] KS_NONE = 4'hF;

   typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_e;
   typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_e;

   function automatic int unsigned joy_btn_bit(input int unsigned idx);
      return 4 + idx;
   endfunction

   function automatic int unsigned joy_start_bit(input int unsigned nbtn);
      return 4 + nbtn;
   endfunction

   function automatic int unsigned joy_coin_bit(input int unsigned nbtn);
      return 5 + nbtn;
   endfunction

   function automatic logic [3:0] key_slot(input logic player, input logic [8:0] code);
      logic [3:0] slot;
      slot = KS_NONE;
      if (!player) begin
         case (code)
            KEY_P0_R:     slot = 4'd0;
            KEY_P0_L:     slot = 4'd1;
            KEY_P0_D:     slot = 4'd2;
            KEY_P0_U:     slot = 4'd3;
            KEY_P0_B0:    slot = 4'd4;
            KEY_P0_B1:    slot = 4'd5;
            KEY_P0_B2:    slot = 4'd6;
            KEY_P0_B3:    slot = 4'd7;
            KEY_P0_START: slot = 4'd8;
            KEY_P0_COIN:  slot = 4'd9;
            default:      slot = KS_NONE;
         endcase
      end else begin
         case (code)
            KEY_P1_R:     slot = 4'd0;
            KEY_P1_L:     slot = 4'd1;
            KEY_P1_D:     slot = 4'd2;
            KEY_P1_U:     slot = 4'd3;
            KEY_P1_B0:    slot = 4'd4;
            KEY_P1_B1:    slot = 4'd5;
            KEY_P1_B2:    slot = 4'd6;
            KEY_P1_B3:    slot = 4'd7;
            KEY_P1_START: slot = 4'd8;
            KEY_P1_COIN:  slot = 4'd9;
            default:      slot = KS_NONE;
         endcase
      end
      return slot;
   endfunction

   // d and result are {U,D,L,R}
   function automatic logic [3:0] rotate_dir(input rot_e r, input logic [3:0] d);
      logic [3:0] o;
      case (r)
         ROT_90:  o = {d[1], d[0], d[2], d[3]};
         ROT_180: o = {d[2], d[3], d[0], d[1]};
         ROT_270: o = {d[0], d[1], d[3], d[2]};
         default: o = d;
      endcase
      return o;
   endfunction

   function automatic logic [3:0] socd_clean(input logic [3:0] d);
      logic [3:0] o;
      o = d;
      if (d[3] && d[2]) o[3:2] = 2'b00;
      if (d[1] && d[0]) o[1:0] = 2'b00;
      return o;
   endfunction

endpackage

// File: rtl/arcade_coin_pulse.sv
// Coin pulse shaper: a fresh rising edge of req gives COIN_PULSE cycles high followed
// by a COIN_PULSE-cycle dead gap; edges during pulse or gap are dropped.
module arcade_coin_pulse
   import arcade_input_pkg::*;
#(
   parameter int unsigned COIN_PULSE = 16
) (
   input  logic clk_sys,
   input  logic RESET_N,
   input  logic req,
   output logic pulse
);

   localparam int unsigned CW = $clog2(COIN_PULSE + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(COIN_PULSE - 1);

   coin_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          req_q;
   logic          pulse_q, pulse_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = pulse_q;
      unique case (state_q)
         IDLE: begin
            if (req && !req_q) begin
               state_d = PULSE;
               cnt_d   = CNT_LOAD;
               pulse_d = 1'b1;
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = CNT_LOAD;
               pulse_d = 1'b0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         default: begin
            state_d = IDLE;
            pulse_d = 1'b0;
         end
      endcase
   end

   // req_q tracks the request in every state so a held request never retriggers
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Player input front end: PS/2 key state + joystick merge, rotation, SOCD and coin pulses.
// Optional autofire gating when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper
   import arcade_input_pkg::*;
#(
   parameter int unsigned PLAYERS    = 2,
   parameter int unsigned NBTN       = 4,
   parameter int unsigned COIN_PULSE = 16
`ifdef ARCADE_INPUT_AUTOFIRE_EN
   ,
   parameter int unsigned AF_PERIOD  = 65536
`endif
) (
   input  logic                    clk_sys,
   input  logic                    RESET_N,
   input  logic [10:0]             ps2_key,
   input  logic [PLAYERS*16-1:0]   joystick,
   input  logic                    joy_merge,
   input  logic [1:0]              rot,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
   input  logic [NBTN-1:0]         autofire_mask,
`endif
   output logic [PLAYERS*4-1:0]    dir_out,
   output logic [PLAYERS*NBTN-1:0] btn_out,
   output logic [PLAYERS-1:0]      start_out,
   output logic [PLAYERS-1:0]      coin_out
);

   localparam int unsigned KEY_PLAYERS = (PLAYERS < 2) ? PLAYERS : 2;
   localparam int unsigned NKEYS       = 10;
   localparam int unsigned START_BIT   = joy_start_bit(NBTN);
   localparam int unsigned COIN_BIT    = joy_coin_bit(NBTN);

   logic                    toggle_q;
   logic                    key_evt;
   logic [NKEYS-1:0]        key_q [KEY_PLAYERS];
   logic [NKEYS-1:0]        key_d [KEY_PLAYERS];
   logic [15:0]             joy_or;
   logic [PLAYERS*4-1:0]    dir_d, dir_q;
   logic [PLAYERS*NBTN-1:0] btn_d, btn_q;
   logic [PLAYERS-1:0]      start_d, start_q;
   logic [NBTN-1:0]         af_gate;

   assign key_evt = ps2_key[10] ^ toggle_q;

   always_comb begin
      for (int unsigned kp = 0; kp < KEY_PLAYERS; kp++) begin
         key_d[kp] = key_q[kp];
         if (key_evt) begin
            for (int unsigned b = 0; b < NKEYS; b++) begin
               if (key_slot(kp != 0, ps2_key[8:0]) == 4'(b)) key_d[kp][b] = ps2_key[9];
            end
         end
      end
   end

   always_comb begin
      joy_or = '0;
      for (int unsigned p = 0; p < PLAYERS; p++) joy_or = joy_or | joystick[16*p +: 16];
   end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
   localparam int unsigned AFW = (AF_PERIOD > 1) ? $clog2(AF_PERIOD) : 1;

   logic [AFW-1:0] af_cnt_q, af_cnt_d;
   logic           phase_q, phase_d;

   always_comb begin
      af_cnt_d = af_cnt_q + AFW'(1);
      phase_d  = phase_q;
      if (af_cnt_q == AFW'(AF_PERIOD - 1)) begin
         af_cnt_d = '0;
         phase_d  = ~phase_q;
      end
   end

   // Phase comes out of reset high so held autofire buttons fire immediately
   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         af_cnt_q <= '0;
         phase_q  <= 1'b1;
      end else begin
         af_cnt_q <= af_cnt_d;
         phase_q  <= phase_d;
      end
   end

   assign af_gate = ~autofire_mask | {NBTN{phase_q}};
`else
   assign af_gate = '1;
`endif

   for (genvar g = 0; g < PLAYERS; g++) begin : g_player
      logic [15:0] key_word;
      logic [15:0] raw;
      logic [15:0] unused_raw;

      if (g < KEY_PLAYERS) begin : g_key
         // Re-pack key state into the joystick word layout for this NBTN
         always_comb begin
            key_word      = '0;
            key_word[3:0] = key_q[g][3:0];
            for (int unsigned i = 0; i < 4; i++) begin
               if (i < NBTN) key_word[joy_btn_bit(i)] = key_q[g][4+i];
            end
            key_word[START_BIT] = key_q[g][8];
            key_word[COIN_BIT]  = key_q[g][9];
         end
      end else begin : g_nokey
         assign key_word = '0;
      end

      assign raw        = key_word | (joy_merge ? joy_or : joystick[16*g +: 16]);
      assign unused_raw = raw;

      assign dir_d[4*g +: 4]       = socd_clean(rotate_dir(rot_e'(rot), raw[3:0]));
      assign btn_d[NBTN*g +: NBTN] = raw[4 +: NBTN] & af_gate;
      assign start_d[g]            = raw[START_BIT];

      arcade_coin_pulse #(
         .COIN_PULSE(COIN_PULSE)
      ) u_coin (
         .clk_sys (clk_sys),
         .RESET_N (RESET_N),
         .req     (raw[COIN_BIT]),
         .pulse   (coin_out[g])
      );
   end

   always_ff @(posedge clk_sys or negedge RESET_N) begin
      if (!RESET_N) begin
         toggle_q <= 1'b0;
         for (int unsigned kp = 0; kp < KEY_PLAYERS; kp++) key_q[kp] <= '0;
         dir_q   <= '0;
         btn_q   <= '0;
         start_q <= '0;
      end else begin
         toggle_q <= ps2_key[10];
         for (int unsigned kp = 0; kp < KEY_PLAYERS; kp++) key_q[kp] <= key_d[kp];
         dir_q   <= dir_d;
         btn_q   <= btn_d;
         start_q <= start_d;
      end
   end

   assign dir_out   = dir_q;
   assign btn_out   = btn_q;
   assign start_out = start_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: vector table, directed keyboard/coin/reset
// sequences, then randomized traffic against a behavioural model.
module tb_arcade_input_mapper;

   localparam int PLAYERS = 2;
   localparam int NBTN    = 4;
   localparam int CP      = 4;

   logic        clk_sys = 1'b0;
   logic        RESET_N = 1'b0;
   logic [10:0] ps2_key = '0;
   logic [31:0] joystick = '0;
   logic        joy_merge = 1'b0;
   logic [1:0]  rot = 2'd0;
   logic [7:0]  dir_out;
   logic [7:0]  btn_out;
   logic [1:0]  start_out;
   logic [1:0]  coin_out;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
   logic [NBTN-1:0] autofire_mask = '0;
`endif

   arcade_input_mapper #(
      .PLAYERS    (PLAYERS),
      .NBTN       (NBTN),
      .COIN_PULSE (CP)
   ) dut (
      .clk_sys   (clk_sys),
      .RESET_N   (RESET_N),
      .ps2_key   (ps2_key),
      .joystick  (joystick),
      .joy_merge (joy_merge),
      .rot       (rot),
`ifdef ARCADE_INPUT_AUTOFIRE_EN
      .autofire_mask (autofire_mask),
`endif
      .dir_out   (dir_out),
      .btn_out   (btn_out),
      .start_out (start_out),
      .coin_out  (coin_out)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Key table per player, index: 0 R, 1 L, 2 D, 3 U, 4..7 b0..b3, 8 start, 9 coin
   logic [8:0] keymap [2][10];
   logic       tog = 1'b0;

   task automatic send_key(input logic pressed, input logic [8:0] code);
      tog     = ~tog;
      ps2_key = {tog, pressed, code};
   endtask

   // ---------------- behavioural model ----------------
   logic [15:0] m_key [2];
   logic        m_tog;
   int          m_cyc;
   logic        m_prev [2];
   int          m_free [2];
   int          m_start [2];
   bit          m_active [2];
   logic [7:0]  e_dir, e_btn;
   logic [1:0]  e_start, e_coin;

   function automatic int jbit(input int k);
      if (k < 8) return k;
      if (k == 8) return 4 + NBTN;
      return 5 + NBTN;
   endfunction

   // Directions as clockwise quarter turns (U0 R1 D2 L3); rotation adds rot turns.
   function automatic logic [3:0] model_dir(input logic [15:0] w, input int r);
      bit a[4];
      bit o[4];
      a[0] = w[3]; a[1] = w[0]; a[2] = w[2]; a[3] = w[1];
      for (int k = 0; k < 4; k++) o[k] = 1'b0;
      for (int k = 0; k < 4; k++) if (a[k]) o[(k + r) % 4] = 1'b1;
      if (o[0] && o[2]) begin o[0] = 1'b0; o[2] = 1'b0; end
      if (o[1] && o[3]) begin o[1] = 1'b0; o[3] = 1'b0; end
      return {o[0], o[2], o[3], o[1]};
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         m_key[p] = '0; m_prev[p] = 1'b0; m_free[p] = 0; m_start[p] = 0; m_active[p] = 1'b0;
      end
      m_tog = 1'b0;
      m_cyc = 0;
   endtask

   // Called at each active edge with the inputs that edge samples
   task automatic model_step();
      logic [15:0] w, jsrc;
      for (int p = 0; p < 2; p++) begin
         jsrc = joy_merge ? (joystick[15:0] | joystick[31:16]) : joystick[16*p +: 16];
         w = m_key[p] | jsrc;
         e_dir[4*p +: 4] = model_dir(w, int'(rot));
         e_btn[4*p +: 4] = w[7:4];
         e_start[p]      = w[4+NBTN];
         if (w[5+NBTN] && !m_prev[p] && m_cyc >= m_free[p]) begin
            m_active[p] = 1'b1;
            m_start[p]  = m_cyc;
            m_free[p]   = m_cyc + 2 * CP + 1;
         end
         e_coin[p] = m_active[p] && ((m_cyc - m_start[p]) < CP);
         m_prev[p] = w[5+NBTN];
      end
      if (ps2_key[10] != m_tog) begin
         m_tog = ps2_key[10];
         for (int p = 0; p < 2; p++)
            for (int k = 0; k < 10; k++)
               if (ps2_key[8:0] == keymap[p][k]) m_key[p][jbit(k)] = ps2_key[9];
      end
      m_cyc++;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [15:0] j0;
      logic [15:0] j1;
      logic        merge;
      logic [1:0]  r;
      logic [7:0]  dir;
      logic [7:0]  btn;
      logic [1:0]  start;
   } vec_t;

   vec_t vecs [10];

   logic req_seq  [16];
   logic coin_exp [16];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      keymap[0] = '{9'h174, 9'h16B, 9'h172, 9'h175, 9'h014, 9'h011, 9'h029, 9'h012,
                    9'h016, 9'h02E};
      keymap[1] = '{9'h034, 9'h023, 9'h02B, 9'h02D, 9'h01C, 9'h01B, 9'h015, 9'h01D,
                    9'h01E, 9'h036};

      vecs[0] = '{16'h0002, 16'h0000, 1'b0, 2'd1, 8'h08, 8'h00, 2'b00};
      vecs[1] = '{16'h0002, 16'h0000, 1'b0, 2'd2, 8'h01, 8'h00, 2'b00};
      vecs[2] = '{16'h000E, 16'h0000, 1'b0, 2'd0, 8'h02, 8'h00, 2'b00};
      vecs[3] = '{16'h0000, 16'h0010, 1'b0, 2'd0, 8'h00, 8'h10, 2'b00};
      vecs[4] = '{16'h0000, 16'h0010, 1'b1, 2'd0, 8'h00, 8'h11, 2'b00};
      vecs[5] = '{16'h0100, 16'h0009, 1'b0, 2'd3, 8'hA0, 8'h00, 2'b01};
      vecs[6] = '{16'h000F, 16'h0000, 1'b0, 2'd0, 8'h00, 8'h00, 2'b00};
      vecs[7] = '{16'h0005, 16'h0000, 1'b0, 2'd1, 8'h06, 8'h00, 2'b00};
      vecs[8] = '{16'h0000, 16'h00F3, 1'b0, 2'd0, 8'h00, 8'hF0, 2'b00};
      vecs[9] = '{16'h0001, 16'h0008, 1'b1, 2'd0, 8'h99, 8'h00, 2'b00};

      req_seq  = '{1,1,0,1, 1,1,0,1, 1,1,0,1, 1,1,1,0};
      coin_exp = '{1,1,1,1, 0,0,0,0, 0,0,0,1, 1,1,1,0};

      // Reset state
      repeat (3) @(negedge clk_sys);
      check("reset_outputs", {dir_out, btn_out, start_out, coin_out}, 32'h0);
      RESET_N = 1'b1;

      // Table: joystick / rotation / SOCD / merge
      for (int i = 0; i < 10; i++) begin
         joystick  = {vecs[i].j1, vecs[i].j0};
         joy_merge = vecs[i].merge;
         rot       = vecs[i].r;
         @(negedge clk_sys);
         check($sformatf("vec%0d_dir", i),   dir_out,   vecs[i].dir);
         check($sformatf("vec%0d_btn", i),   btn_out,   vecs[i].btn);
         check($sformatf("vec%0d_start", i), start_out, vecs[i].start);
         check($sformatf("vec%0d_coin", i),  coin_out,  2'b00);
      end
      joystick = '0; joy_merge = 1'b0; rot = 2'd0;
      @(negedge clk_sys);

      // Keyboard: press P0 up (extended), latency of two edges to the output
      send_key(1'b1, 9'h175);
      @(negedge clk_sys);
      check("kb_press_early", dir_out, 8'h00);
      @(negedge clk_sys);
      check("kb_press_up", dir_out, 8'h08);
      send_key(1'b0, 9'h175);
      @(negedge clk_sys);
      check("kb_release_early", dir_out, 8'h08);
      @(negedge clk_sys);
      check("kb_release_up", dir_out, 8'h00);
      send_key(1'b1, 9'h075);
      repeat (2) @(negedge clk_sys);
      check("kb_ext_mismatch", dir_out, 8'h00);
      rot = 2'd1;
      send_key(1'b1, 9'h034);
      @(negedge clk_sys);
      send_key(1'b1, 9'h029);
      repeat (2) @(negedge clk_sys);
      check("kb_p1_right_rot90", dir_out, 8'h40);
      check("kb_p0_b2", btn_out, 8'h04);
      send_key(1'b0, 9'h034);
      @(negedge clk_sys);
      send_key(1'b0, 9'h029);
      rot = 2'd0;
      repeat (2) @(negedge clk_sys);
      check("kb_all_released", {dir_out, btn_out}, 16'h0);

      // Coin pulse / gap / dropped edges on player 0 joystick coin bit
      for (int e = 0; e < 16; e++) begin
         joystick[9] = req_seq[e];
         @(negedge clk_sys);
         check($sformatf("coin_e%0d", e), coin_out, {1'b0, coin_exp[e]});
      end
      joystick = '0;
      repeat (12) @(negedge clk_sys);

      // Reset while a pulse is active and keys are held
      if (tog) send_key(1'b0, 9'h0FF);
      @(negedge clk_sys);
      send_key(1'b1, 9'h175);
      @(negedge clk_sys);
      send_key(1'b1, 9'h014);
      repeat (2) @(negedge clk_sys);
      joystick[9] = 1'b1;
      @(negedge clk_sys);
      check("pre_reset_state", {dir_out, btn_out, coin_out}, {8'h08, 8'h01, 2'b01});
      #2 RESET_N = 1'b0;
      #1 check("reset_async_drop", {dir_out, btn_out, start_out, coin_out}, 32'h0);
      joystick = '0;
      @(negedge clk_sys);
      RESET_N = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_sys);
         check($sformatf("post_reset_hold%0d", i), {dir_out, btn_out, start_out, coin_out},
               32'h0);
      end
      send_key(1'b1, 9'h175);
      repeat (2) @(negedge clk_sys);
      check("post_reset_new_press", dir_out, 8'h08);

      // Randomized traffic against the model
      RESET_N = 1'b0;
      ps2_key = '0; joystick = '0; joy_merge = 1'b0; rot = 2'd0; tog = 1'b0;
      @(negedge clk_sys);
      RESET_N = 1'b1;
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 5) == 0) begin
            logic [8:0] code;
            if ($urandom_range(0, 4) == 0) code = 9'($urandom);
            else code = keymap[$urandom_range(0, 1)][$urandom_range(0, 9)];
            send_key(1'($urandom_range(0, 1)), code);
         end
         if ($urandom_range(0, 3) == 0)
            joystick = {16'($urandom & $urandom), 16'($urandom & $urandom)} & 32'h03FF_03FF;
         if ($urandom_range(0, 19) == 0) rot = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 39) == 0) joy_merge = ~joy_merge;
         @(posedge clk_sys);
         model_step();
         @(negedge clk_sys);
         check($sformatf("rand_c%0d", c), {dir_out, btn_out, start_out, coin_out},
               {8'h0, e_dir, e_btn, e_start, e_coin});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
